mult_result_fifo: RTL and testbench

//  Downstream stage of the 4x4 shift-add multiplier (mult4x4).

---
 rtl/mult_result_fifo.sv | 145 ++++++++++++++
 tb/tb_mult_result_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_fifo.sv
// mult_result_fifo: result queue behind the 4x4 shift-add multiplier.
// Captures one product per Done rising edge, buffers it in a small FIFO
// with a valid/ready output, keeps a running sum of accepted products and
// throttles the multiplier through st_en while no result slot is free.
module mult_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int PROD_W = 8,
    parameter int SUM_W  = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Done,
    input  logic [8:0]                 ACC,
    output logic                       st_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PROD_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [SUM_W-1:0]           sum,
    output logic                       overflow,
    output logic                       drop,
    output logic                       acc_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Adds a zero-extended product to the running sum and returns
    // {carry, wrapped sum}; the carry feeds the sticky overflow flag.
    function automatic logic [SUM_W:0] add_wrap(
        input logic [SUM_W-1:0]  acc_sum,
        input logic [PROD_W-1:0] prod
    );
        logic [SUM_W:0] ext_sum;
        logic [SUM_W:0] ext_prod;
        ext_sum  = {1'b0, acc_sum};
        ext_prod = {{(SUM_W + 1 - PROD_W){1'b0}}, prod};
        return ext_sum + ext_prod;
    endfunction

    // Next occupancy: +1 on push only, -1 on pop only, else unchanged.
    function automatic logic [CW-1:0] next_count(
        input logic [CW-1:0] cur,
        input logic          do_push,
        input logic          do_pop
    );
        logic [CW-1:0] res;
        res = cur;
        if (do_push && !do_pop) begin
            res = cur + 1'b1;
        end else if (!do_push && do_pop) begin
            res = cur - 1'b1;
        end
        return res;
    endfunction

    logic [PROD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              done_q;
    logic              cap;
    logic              pop;
    logic              push;
    logic              lost;
    logic [SUM_W:0]    sum_next;

    // Status and handshake decode from the occupancy counter.
    always_comb begin
        full      = (count == CW'(DEPTH));
        empty     = (count == '0);
        st_en     = ~full;
        out_valid = ~empty;
        out_data  = empty ? '0 : mem[rd_ptr];
    end

    // Event decode: one capture per Done rising edge; a pop in the same
    // cycle frees the slot a capture into a full FIFO needs.
    always_comb begin
        cap      = Done & ~done_q;
        pop      = out_valid & out_ready;
        push     = cap & (~full | pop);
        lost     = cap & full & ~pop;
        sum_next = add_wrap(sum, ACC[PROD_W-1:0]);
    end

    // Done edge detector; held at 1 in reset so a Done that is already
    // high when reset releases is not mistaken for a new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b1;
        end else begin
            done_q <= Done;
        end
    end

    // FIFO storage; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ACC[PROD_W-1:0];
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= next_count(count, push, pop);
        end
    end

    // Running sum of accepted products and the sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum      <= '0;
            overflow <= 1'b0;
            drop     <= 1'b0;
            acc_err  <= 1'b0;
        end else begin
            if (push) begin
                sum <= sum_next[SUM_W-1:0];
                if (sum_next[SUM_W]) begin
                    overflow <= 1'b1;
                end
            end
            if (lost) begin
                drop <= 1'b1;
            end
            if (cap && ACC[8]) begin
                acc_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_result_fifo.sv
// Bench for mult_result_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based reference model and a data scoreboard.
module tb_mult_result_fifo;

    localparam int DEPTH  = 4;
    localparam int PROD_W = 8;
    localparam int SUM_W  = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              Done = 1'b0;
    logic [8:0]        ACC = '0;
    logic              st_en;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PROD_W-1:0] out_data;
    logic [2:0]        count;
    logic              full;
    logic              empty;
    logic [SUM_W-1:0]  sum;
    logic              overflow;
    logic              drop;
    logic              acc_err;

    int total = 0;
    int bad   = 0;

    // reference model state
    int mq[$];
    int sb[$];
    int m_sum = 0;
    bit m_ovf = 0, m_drop = 0, m_err = 0;
    bit done_prev = 1;
    bit started = 0;

    mult_result_fifo #(.DEPTH(DEPTH), .PROD_W(PROD_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .Done(Done), .ACC(ACC), .st_en(st_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty), .sum(sum),
        .overflow(overflow), .drop(drop), .acc_err(acc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, sum as plain integer arithmetic.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            sb.delete();
            m_sum = 0; m_ovf = 0; m_drop = 0; m_err = 0;
            done_prev = 1;
            started = 1;
        end else begin
            bit cap, pop, acc_ok;
            int prod;
            cap    = Done && !done_prev;
            pop    = (mq.size() > 0) && out_ready;
            acc_ok = cap && ((mq.size() < DEPTH) || pop);
            prod   = int'(ACC[7:0]);
            if (pop) void'(mq.pop_front());
            if (acc_ok) begin
                mq.push_back(prod);
                sb.push_back(prod);
                m_sum = m_sum + prod;
                if (m_sum >= 4096) begin
                    m_ovf = 1;
                    m_sum = m_sum - 4096;
                end
            end
            if (cap && !acc_ok) m_drop = 1;
            if (cap && ACC[8]) m_err = 1;
            done_prev = Done;
        end
    end

    // Monitor: status against the model, popped data against the scoreboard.
    always @(negedge clk) begin
        if (started) begin
            chk("count", int'(count), mq.size());
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("empty", int'(empty), int'(mq.size() == 0));
            chk("st_en", int'(st_en), int'(mq.size() != DEPTH));
            chk("out_valid", int'(out_valid), int'(mq.size() != 0));
            chk("sum", int'(sum), m_sum);
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("drop", int'(drop), int'(m_drop));
            chk("acc_err", int'(acc_err), int'(m_err));
            if (mq.size() == 0) chk("out_data_empty", int'(out_data), 0);
            if (out_valid && out_ready && !rst) begin
                if (sb.size() == 0) begin
                    chk("pop_unexpected", int'(out_data), -1);
                end else begin
                    chk("pop_data", int'(out_data), sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; Done = 0; out_ready = 0;
        tick(); tick();
        rst = 0;
        tick();
    endtask

    task automatic pulse(input logic [8:0] v);
        Done = 1; ACC = v;
        tick();
        Done = 0;
        tick();
    endtask

    initial begin
        // 1: reset with Done held high
        rst = 1; Done = 1; ACC = 9'h007;
        tick(); tick();
        rst = 0;
        tick(); tick();
        chk("t1_empty", int'(empty), 1);
        chk("t1_count", int'(count), 0);
        chk("t1_sum", int'(sum), 0);
        chk("t1_st_en", int'(st_en), 1);
        chk("t1_out_valid", int'(out_valid), 0);
        chk("t1_out_data", int'(out_data), 0);
        Done = 0;
        tick();

        // 2: single capture, one cycle latency
        do_reset();
        ACC = 9'h004; Done = 1;
        tick();
        chk("t2_out_valid", int'(out_valid), 1);
        chk("t2_out_data", int'(out_data), 4);
        chk("t2_count", int'(count), 1);
        chk("t2_sum", int'(sum), 4);
        Done = 0;
        tick();

        // 3: Done held for several cycles captures once
        do_reset();
        ACC = 9'h009; Done = 1;
        repeat (5) tick();
        Done = 0;
        tick();
        chk("t3_count", int'(count), 1);
        chk("t3_sum", int'(sum), 9);

        // 4: fill, drop on full, simultaneous pop+push when full
        do_reset();
        for (int i = 1; i <= 4; i++) pulse(9'(i));
        chk("t4_full", int'(full), 1);
        chk("t4_st_en", int'(st_en), 0);
        chk("t4_sum", int'(sum), 10);
        pulse(9'd5);
        chk("t4_drop", int'(drop), 1);
        chk("t4_count_drop", int'(count), 4);
        chk("t4_sum_drop", int'(sum), 10);
        out_ready = 1; Done = 1; ACC = 9'd6;
        tick();
        chk("t4_count_both", int'(count), 4);
        chk("t4_head", int'(out_data), 2);
        Done = 0;
        repeat (6) tick();
        chk("t4_drained", int'(empty), 1);

        // 5: running sum overflow
        do_reset();
        out_ready = 1;
        repeat (19) pulse(9'h0E1);
        chk("t5_overflow", int'(overflow), 1);
        chk("t5_sum", int'(sum), 179);
        chk("t5_drop", int'(drop), 0);

        // 6: ACC carry flag, then reset with data queued
        do_reset();
        Done = 1; ACC = 9'h1FF;
        tick();
        chk("t6_acc_err", int'(acc_err), 1);
        chk("t6_out_data", int'(out_data), 255);
        Done = 0;
        tick();
        pulse(9'h003);
        chk("t6_count", int'(count), 2);
        rst = 1;
        tick();
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_empty", int'(empty), 1);
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_data", int'(out_data), 0);
        chk("t6_rst_sum", int'(sum), 0);
        chk("t6_rst_err", int'(acc_err), 0);
        chk("t6_rst_st_en", int'(st_en), 1);
        rst = 0;
        tick();

        // randomized traffic with alternating consumer pressure
        for (int c = 0; c < 3000; c++) begin
            bit slow;
            slow = ((c / 100) % 2) == 0;
            rst  = ($urandom_range(0, 399) == 0);
            Done = 1'($urandom_range(0, 1));
            ACC  = {1'($urandom_range(0, 15) == 0), 8'($urandom)};
            out_ready = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 0; Done = 0; out_ready = 1;
        repeat (8) tick();
        chk("final_empty", int'(empty), 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
